dfsr_scan_bank: RTL and testbench

//  WIDTH-bit bank of D flip-flops with per-bit synchronous set/clear and a shadow scan rank.

---
 rtl/dfsr_scan_bank.sv | 137 +++++++++++++
 tb/tb_dfsr_scan_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dfsr_scan_bank.sv
// dfsr_scan_bank: multi-bit D flip-flop bank with per-bit synchronous set/clear,
// a parallel load enable and a shadow scan rank. The shadow rank shifts serially
// (SI in at bit 0, SO out from the top bit), captures the functional rank (CAP)
// and updates the functional rank from its contents (UPD). A sticky flag records
// any cycle in which some bit had both its clear and its set asserted.
module dfsr_scan_bank #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]     SR_RST  = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPW,
  input  logic             VNW,
  input  logic             VDD,
  input  logic             VSS,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic [WIDTH-1:0] RN,
  input  logic [WIDTH-1:0] SN,
  input  logic             SE,
  input  logic             SI,
  input  logic             CAP,
  input  logic             UPD,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             CONFLICT
);

  // Functional rank, shadow rank and sticky conflict flag.
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_s;
  logic             r_conflict;

  // Combinational next-state values.
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_s_shift;
  logic [WIDTH-1:0] w_s_nxt;
  logic             w_conflict_hit;

  // Bias and supply pins are carried for netlist compatibility only; they are
  // gathered here so they are visibly consumed without affecting behaviour.
  logic             w_unused_bias;
  assign w_unused_bias = VPW ^ VNW ^ VDD ^ VSS;

  // Next value of one functional bit. Nested if/else gives strict priority, so
  // an unknown on a lower-priority control cannot reach the result while a
  // higher-priority term is active.
  function automatic logic q_bit_next(
    input logic rn,
    input logic sn,
    input logic upd,
    input logic s_bit,
    input logic en,
    input logic d_bit,
    input logic q_bit
  );
    logic nxt;
    if (rn == 1'b0) begin
      nxt = 1'b0;
    end else if (sn == 1'b0) begin
      nxt = 1'b1;
    end else if (upd == 1'b1) begin
      nxt = s_bit;
    end else if (en == 1'b1) begin
      nxt = d_bit;
    end else begin
      nxt = q_bit;
    end
    return nxt;
  endfunction

  // Next value of the whole shadow rank: capture beats shift beats hold.
  function automatic logic [WIDTH-1:0] s_rank_next(
    input logic             cap,
    input logic             se,
    input logic [WIDTH-1:0] q_now,
    input logic [WIDTH-1:0] s_shifted,
    input logic [WIDTH-1:0] s_now
  );
    logic [WIDTH-1:0] nxt;
    if (cap == 1'b1) begin
      nxt = q_now;
    end else if (se == 1'b1) begin
      nxt = s_shifted;
    end else begin
      nxt = s_now;
    end
    return nxt;
  endfunction

  // Shifted shadow value; a single-bit rank simply takes SI.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign w_s_shift = SI;
    end else begin : g_shift_many
      assign w_s_shift = {r_s[WIDTH-2:0], SI};
    end
  endgenerate

  // Per-bit functional next state from the pre-edge shadow and data inputs.
  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      w_q_nxt[i] = q_bit_next(RN[i], SN[i], UPD, r_s[i], EN, D[i], r_q[i]);
    end
  end

  // Shadow next state; capture samples the pre-edge functional rank, which
  // makes CAP together with UPD a swap of the two ranks.
  always_comb begin
    w_s_nxt = s_rank_next(CAP, SE, r_q, w_s_shift, r_s);
  end

  // Any bit with clear and set asserted together raises the conflict flag.
  always_comb begin
    w_conflict_hit = |(~RN & ~SN);
  end

  // State registers; reset overrides every other input in its cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q        <= RST_VAL;
      r_s        <= SR_RST;
      r_conflict <= 1'b0;
    end else begin
      r_q        <= w_q_nxt;
      r_s        <= w_s_nxt;
      r_conflict <= r_conflict | w_conflict_hit;
    end
  end

  assign Q        = r_q;
  assign SO       = r_s[WIDTH-1];
  assign CONFLICT = r_conflict;

endmodule

// File: tb/tb_dfsr_scan_bank.sv
// Directed self-checking bench for dfsr_scan_bank (WIDTH=8, zero reset values).
module tb_dfsr_scan_bank;

  logic       CLK;
  logic       RST;
  logic       VPW, VNW, VDD, VSS;
  logic [7:0] D;
  logic       EN;
  logic [7:0] RN;
  logic [7:0] SN;
  logic       SE;
  logic       SI;
  logic       CAP;
  logic       UPD;
  logic [7:0] Q;
  logic       SO;
  logic       CONFLICT;

  int n_pass  = 0;
  int n_total = 0;

  dfsr_scan_bank #(.WIDTH(8), .RST_VAL(8'h00), .SR_RST(8'h00)) dut (
    .CLK(CLK), .RST(RST), .VPW(VPW), .VNW(VNW), .VDD(VDD), .VSS(VSS),
    .D(D), .EN(EN), .RN(RN), .SN(SN), .SE(SE), .SI(SI),
    .CAP(CAP), .UPD(UPD), .Q(Q), .SO(SO), .CONFLICT(CONFLICT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    RST = 1'b0; EN = 1'b0; D = 8'h00; RN = 8'hFF; SN = 8'hFF;
    SE = 1'b0; SI = 1'b0; CAP = 1'b0; UPD = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    VPW = 1'b0; VNW = 1'b1; VDD = 1'b1; VSS = 1'b0;
    idle();
    #2;

    // Reset overrides a simultaneous parallel load
    RST = 1'b1; EN = 1'b1; D = 8'h55;
    step();
    idle();
    chk("rst_q", Q, 8'h00);
    chk("rst_so", {7'd0, SO}, 8'h00);
    chk("rst_conflict", {7'd0, CONFLICT}, 8'h00);

    // Parallel load and hold
    EN = 1'b1; D = 8'hA5; step();
    chk("load_a5", Q, 8'hA5);
    EN = 1'b0; D = 8'hFF; step();
    chk("hold_a5", Q, 8'hA5);

    // Per-bit clear on bit0, set on bit7, load zeros elsewhere
    RN = 8'hFE; SN = 8'h7F; EN = 1'b1; D = 8'h00; step();
    chk("setclr_q", Q, 8'h80);
    chk("setclr_noconf", {7'd0, CONFLICT}, 8'h00);
    idle();

    // Serial scan load 1,0,1,1,0,0,1,1 then update (UPD beats EN)
    pat = 8'b1011_0011;
    SE = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      SI = pat[k];
      step();
    end
    chk("shift_q_held", Q, 8'h80);
    chk("shift_so_msb", {7'd0, SO}, 8'h01);
    SE = 1'b0; SI = 1'b0; UPD = 1'b1; EN = 1'b1; D = 8'h00; step();
    chk("upd_q", Q, 8'hB3);
    idle();

    // Capture 3C and read it out MSB first
    EN = 1'b1; D = 8'h3C; step();
    idle();
    CAP = 1'b1; step();
    CAP = 1'b0;
    chk("cap_q_kept", Q, 8'h3C);
    pat = 8'h3C;
    SE = 1'b1; SI = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("readout_3c_k%0d", k), {7'd0, SO}, {7'd0, pat[7-k]});
      step();
    end
    idle();

    // Q=0F, S=F0, then swap (CAP beats SE)
    EN = 1'b1; D = 8'h0F; step();
    idle();
    pat = 8'hF0;
    SE = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      SI = pat[k];
      step();
    end
    chk("pre_swap_q", Q, 8'h0F);
    chk("pre_swap_so", {7'd0, SO}, 8'h01);
    SE = 1'b1; SI = 1'b1; CAP = 1'b1; UPD = 1'b1; step();
    idle();
    chk("swap_q", Q, 8'hF0);
    pat = 8'h0F;
    SE = 1'b1; SI = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("swap_s_k%0d", k), {7'd0, SO}, {7'd0, pat[7-k]});
      step();
    end
    idle();

    // Set/clear conflict on bit0: clear wins, flag is sticky
    RN = 8'hFE; SN = 8'hFE; EN = 1'b1; D = 8'hFF; step();
    chk("conflict_q", Q, 8'hFE);
    chk("conflict_set", {7'd0, CONFLICT}, 8'h01);
    idle();
    step(); step();
    chk("conflict_sticky", {7'd0, CONFLICT}, 8'h01);
    chk("conflict_q_hold", Q, 8'hFE);

    // Reset clears the flag and both ranks
    RST = 1'b1; step();
    idle();
    chk("rst2_conflict", {7'd0, CONFLICT}, 8'h00);
    chk("rst2_q", Q, 8'h00);

    // Reset mid-shift discards the partial shift
    SE = 1'b1; SI = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("midshift_so", {7'd0, SO}, 8'h00);
    RST = 1'b1; step();
    RST = 1'b0;
    chk("midshift_rst_so", {7'd0, SO}, 8'h00);
    SI = 1'b0; step();
    chk("midshift_restart_so", {7'd0, SO}, 8'h00);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
